// File: rtl/led_round_sequencer_if.sv
// Round-driver bus for the LED reaction game: go request in, round status and LED strobes out.
interface led_round_sequencer_if;
    logic       go;
    logic       start;
    logic       change;
    logic [1:0] randNum;
    logic [6:0] time_left;
    logic       done;

    modport master (
        output go,
        input  start, change, randNum, time_left, done
    );

    modport slave (
        input  go,
        output start, change, randNum, time_left, done
    );
endinterface

// File: rtl/led_round_sequencer.sv
// Timed round driver: on go, runs GAME_SECS seconds emitting periodic change strobes with an LFSR LED index.
// Optional build macro LED_SEQ_SPEEDUP_EN halves the change period for the second half of the round.
module led_round_sequencer #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned GAME_SECS     = 60,
    parameter int unsigned CHANGE_TICKS  = 25_000_000,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    led_round_sequencer_if.slave   bus
);

    localparam int unsigned SEC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned CHG_W = (CHANGE_TICKS > 1) ? $clog2(CHANGE_TICKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [7:0]        r_lfsr;
    logic [SEC_W-1:0]  r_sec_cnt;
    logic [CHG_W-1:0]  r_chg_cnt;
    logic              r_start;
    logic              r_change;
    logic [1:0]        r_randNum;
    logic [6:0]        r_time_left;
    logic              r_done;

    logic              w_lfsr_fb;
    logic [7:0]        w_lfsr_next;
    logic [1:0]        w_pick;
    logic [CHG_W-1:0]  w_chg_last;
    logic              w_chg_wrap;
    logic              w_sec_wrap;
    logic              w_round_end;

    // x^8+x^6+x^5+x^4+1; a stuck all-zero state is recovered by reloading the seed
    assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_lfsr_next = (r_lfsr == 8'd0) ? LFSR_SEED : {r_lfsr[6:0], w_lfsr_fb};

    // Index 3 is not a valid LED, so it advances the previous index instead
    assign w_pick = (r_lfsr[1:0] != 2'd3) ? r_lfsr[1:0] :
                    (r_randNum == 2'd2)   ? 2'd0 : r_randNum + 2'd1;

`ifdef LED_SEQ_SPEEDUP_EN
    localparam int unsigned HALF_SECS = GAME_SECS / 2;
    assign w_chg_last = (r_time_left <= 7'(HALF_SECS)) ? CHG_W'(CHANGE_TICKS / 2 - 1)
                                                      : CHG_W'(CHANGE_TICKS - 1);
`else
    assign w_chg_last = CHG_W'(CHANGE_TICKS - 1);
`endif

    assign w_chg_wrap  = (r_chg_cnt >= w_chg_last);
    assign w_sec_wrap  = (r_sec_cnt >= SEC_W'(TICKS_PER_SEC - 1));
    assign w_round_end = w_sec_wrap && (r_time_left <= 7'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_lfsr      <= LFSR_SEED;
            r_sec_cnt   <= '0;
            r_chg_cnt   <= '0;
            r_start     <= 1'b0;
            r_change    <= 1'b0;
            r_randNum   <= 2'd0;
            r_time_left <= 7'd0;
            r_done      <= 1'b0;
        end else begin
            r_lfsr   <= w_lfsr_next;
            r_change <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.go) begin
                        r_state     <= ST_RUN;
                        r_start     <= 1'b1;
                        r_change    <= 1'b1;
                        r_randNum   <= w_pick;
                        r_time_left <= 7'(GAME_SECS);
                        r_sec_cnt   <= '0;
                        r_chg_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_round_end) begin
                        // a change wrap landing on the final cycle is dropped
                        r_state     <= ST_DONE;
                        r_start     <= 1'b0;
                        r_time_left <= 7'd0;
                        r_done      <= 1'b1;
                        r_sec_cnt   <= '0;
                        r_chg_cnt   <= '0;
                    end else begin
                        if (w_sec_wrap) begin
                            r_sec_cnt   <= '0;
                            r_time_left <= r_time_left - 7'd1;
                        end else begin
                            r_sec_cnt   <= r_sec_cnt + SEC_W'(1);
                        end
                        if (w_chg_wrap) begin
                            r_chg_cnt <= '0;
                            r_change  <= 1'b1;
                            r_randNum <= w_pick;
                        end else begin
                            r_chg_cnt <= r_chg_cnt + CHG_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.start     = r_start;
    assign bus.change    = r_change;
    assign bus.randNum   = r_randNum;
    assign bus.time_left = r_time_left;
    assign bus.done      = r_done;

endmodule
